// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the CARP fetch-stage program-counter generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } pc_state_e;

   typedef enum logic [2:0] {
      SEL_TRAP,
      SEL_MRET,
      SEL_REDIR,
      SEL_INC,
      SEL_HOLD
   } pc_sel_e;

   localparam int unsigned PC_MAX_W = 64;

   // Clears the low lsb bits; callers zero-extend into and truncate out of PC_MAX_W.
   function automatic logic [PC_MAX_W-1:0] align_pc(input logic [PC_MAX_W-1:0] addr,
                                                    input int unsigned lsb);
      return addr & ~((PC_MAX_W'(1) << lsb) - PC_MAX_W'(1));
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: fixed-priority source pick, increment,
// target alignment and misalignment detection.
module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned INC  = 4
) (
   input  logic            i_active,
   input  logic            i_fire,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_trap_valid,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic            i_mret_valid,
   input  logic [XLEN-1:0] i_mepc,
   input  logic            i_redir_valid,
   input  logic [XLEN-1:0] i_redir_pc,
   output logic [XLEN-1:0] o_next_pc,
   output logic            o_misalign,
   output logic [XLEN-1:0] o_target
);

   localparam int unsigned ALIGN_LSB = $clog2(INC);

   pc_sel_e         w_sel;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_aligned;

   always_comb begin
      w_sel = SEL_HOLD;
      if (i_active) begin
         if (i_trap_valid)       w_sel = SEL_TRAP;
         else if (i_mret_valid)  w_sel = SEL_MRET;
         else if (i_redir_valid) w_sel = SEL_REDIR;
         else if (i_fire)        w_sel = SEL_INC;
      end
   end

   always_comb begin
      w_target = i_redir_pc;
      case (w_sel)
         SEL_TRAP: w_target = i_trap_vec;
         SEL_MRET: w_target = i_mepc;
         default:  w_target = i_redir_pc;
      endcase
   end

   assign w_aligned = XLEN'(align_pc(PC_MAX_W'(w_target), ALIGN_LSB));

   always_comb begin
      o_next_pc  = i_pc;
      o_misalign = 1'b0;
      case (w_sel)
         SEL_TRAP, SEL_MRET, SEL_REDIR: begin
            o_next_pc  = w_aligned;
            o_misalign = (w_aligned != w_target);
         end
         // Wraps modulo 2^XLEN by construction.
         SEL_INC:  o_next_pc = i_pc + XLEN'(INC);
         default:  o_next_pc = i_pc;
      endcase
   end

   assign o_target = w_target;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, runs the BOOT/RUN/HALT
// control and records misaligned redirect targets.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int unsigned     INC       = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            fetch_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            mret_valid_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            halt_i,
   input  logic            resume_i,
   output logic            halted_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] badaddr_o
);

   pc_state_e       r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_pc_valid;
   logic            r_halted;
   logic            r_misalign;
   logic [XLEN-1:0] r_badaddr;

   logic            w_active;
   logic            w_fire;
   logic [XLEN-1:0] w_next_pc;
   logic            w_misalign;
   logic [XLEN-1:0] w_target;

   // Redirect-class loads are honoured in RUN and HALT; BOOT ignores all inputs.
   assign w_active = (r_state != BOOT);
   assign w_fire   = r_pc_valid && fetch_ready_i;

   pc_next_sel #(
      .XLEN (XLEN),
      .INC  (INC)
   ) u_next_sel (
      .i_active      (w_active),
      .i_fire        (w_fire),
      .i_pc          (r_pc),
      .i_trap_valid  (trap_valid_i),
      .i_trap_vec    (trap_vec_i),
      .i_mret_valid  (mret_valid_i),
      .i_mepc        (mepc_i),
      .i_redir_valid (redirect_valid_i),
      .i_redir_pc    (redirect_pc_i),
      .o_next_pc     (w_next_pc),
      .o_misalign    (w_misalign),
      .o_target      (w_target)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VEC;
         r_pc_valid <= 1'b0;
         r_halted   <= 1'b0;
         r_misalign <= 1'b0;
         r_badaddr  <= '0;
      end else begin
         r_pc       <= w_next_pc;
         r_misalign <= w_misalign;
         if (w_misalign) r_badaddr <= w_target;
         case (r_state)
            BOOT: begin
               r_state    <= RUN;
               r_pc_valid <= 1'b1;
               r_halted   <= 1'b0;
            end
            RUN: begin
               if (halt_i) begin
                  r_state    <= HALT;
                  r_pc_valid <= 1'b0;
                  r_halted   <= 1'b1;
               end
            end
            HALT: begin
               if (resume_i && !halt_i) begin
                  r_state    <= RUN;
                  r_pc_valid <= 1'b1;
                  r_halted   <= 1'b0;
               end
            end
            default: begin
               r_state    <= BOOT;
               r_pc_valid <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o       = r_pc;
   assign pc_valid_o = r_pc_valid;
   assign halted_o   = r_halted;
   assign misalign_o = r_misalign;
   assign badaddr_o  = r_badaddr;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the CARP core fetch stage.
- Holds the current fetch PC and presents it to fetch with a valid/ready handshake.
- Selects the next PC by fixed priority: trap vector, exception return (mepc), branch/jump redirect, sequential increment.
- Adds a boot cycle, halt/resume control and misaligned-target reporting.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000 (XLEN bits), PC value loaded on reset.
- INC, 4, sequential increment in bytes; power of two, 2 or 4. ALIGN_LSB = log2(INC).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- fetch_ready_i  in  1  fetch accepts pc_o this cycle
- pc_o  out  XLEN  current fetch PC
- pc_valid_o  out  1  pc_o valid for fetch
- trap_valid_i  in  1  take trap this cycle
- trap_vec_i  in  XLEN  trap target
- mret_valid_i  in  1  exception return this cycle
- mepc_i  in  XLEN  return target
- redirect_valid_i  in  1  branch/jump redirect
- redirect_pc_i  in  XLEN  redirect target
- halt_i  in  1  request halt (level)
- resume_i  in  1  leave halt (pulse)
- halted_o  out  1  block is in HALT
- misalign_o  out  1  one-cycle pulse: last loaded target was misaligned
- badaddr_o  out  XLEN  unmodified misaligned target, held until next misalign

Behaviour:
- Reset (async assert, sync release):
  - pc_q = RESET_VEC, state = BOOT.
  - pc_valid_o = 0, halted_o = 0, misalign_o = 0, badaddr_o = 0.
- States: BOOT, RUN, HALT.
  - BOOT: pc_valid_o = 0. Goes unconditionally to RUN on the next edge; inputs are ignored.
  - RUN: pc_valid_o = 1. fire = pc_valid_o && fetch_ready_i.
  - HALT: pc_valid_o = 0, halted_o = 1.
- Next-PC priority in RUN, evaluated every cycle and registered at the edge (1-cycle latency to pc_o):
  - trap_valid_i -> trap_vec_i.
  - else mret_valid_i -> mepc_i.
  - else redirect_valid_i -> redirect_pc_i.
  - else fire -> pc_q + INC.
  - else hold.
- Redirect-class loads (trap, mret, redirect) do not depend on fetch_ready_i. They flush the current PC even when fetch has not accepted it.
- Sequential increment is modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0 with no flag.
- Misalignment check on any redirect-class target with nonzero bits [ALIGN_LSB-1:0]:
  - Load the target with those bits cleared.
  - Pulse misalign_o for exactly the cycle after the load.
  - Capture the raw target into badaddr_o.
  - Sequential increments never set misalign.
- Halt:
  - RUN -> HALT at the edge where halt_i = 1.
  - A fire or redirect in that same cycle still updates pc_q.
- While in HALT:
  - pc_q holds.
  - Redirect-class inputs still load pc_q with the same priority and misalign rules, so resume fetches from the new target.
  - fetch_ready_i is ignored.
- HALT -> RUN at the edge where resume_i = 1 and halt_i = 0. If both are 1, stay in HALT.
- resume_i in RUN or BOOT is ignored.
- Simultaneous trap + mret + redirect: trap wins, the others are dropped.
- Reset asserted mid-operation: immediate return to reset values regardless of state.
- pc_o is driven directly from the register (no combinational path from inputs). next_pc is internal.

Decomposition:
- Package pc_gen_pkg:
  - pc_state_e {BOOT, RUN, HALT}.
  - pc_sel_e {SEL_TRAP, SEL_MRET, SEL_REDIR, SEL_INC, SEL_HOLD}.
  - Function align_pc(addr, lsb).
- Sub-module pc_next_sel (combinational): priority encode into pc_sel_e, next-PC mux, increment, misalign detect.
- pc_gen holds the registers, the state machine and the misalign/badaddr capture.

Test Plan:
- Reset, RESET_VEC = 0x100, fetch_ready_i = 1 -> pc_valid_o = 0 in the first cycle after release, then pc_o = 0x100, 0x104, 0x108 on successive cycles.
- fetch_ready_i = 0 for 3 cycles, then redirect_valid_i with redirect_pc_i = 0x2000 while ready = 0 -> pc_o holds 0x108, then is 0x2000 the next cycle.
- trap (0x80), mret (0x400) and redirect (0x900) in the same cycle -> pc_o = 0x80; next cycle with ready -> 0x84.
- redirect_pc_i = 0x1006 -> pc_o = 0x1004, misalign_o high for one cycle, badaddr_o = 0x1006 held afterward.
- halt_i with fire at pc 0x200 -> pc_o = 0x204, halted_o = 1, pc_valid_o = 0. Redirect to 0x300 while halted, then resume_i -> RUN with pc_o = 0x300.
- pc_q = 0xFFFF_FFFC with fire -> pc_o = 0x0, misalign_o = 0.
